asic_iopoc_ctrl: RTL and testbench
==================================

Name: asic_iopoc_ctrl

Overview:
- Generates the padring power-on-control (poc) line. Padring supply and ground cells carry poc as a feed-through; IO cells use it to hold pads in a safe state.
- Watches the IO and core supply-good detectors, debounces them, and enforces a hold time. Releases IOs only after a core handshake.
- Re-asserts poc immediately on a supply drop. Sits in the always-on core domain beside the padring.

Parameters:
- HOLD, 16, cycles poc stays asserted after supplies are debounced good (>=2)
- DEBOUNCE, 4, consecutive good samples required on both supplies (>=1)
- CNTW, 16, counter width; must hold max(HOLD, DEBOUNCE, WDOG)
- WDOG, 4096, ARMED-state timeout in cycles (used only with the optional feature)

Ports:
- clk  input  1  core clock
- nreset  input  1  asynchronous active-low reset
- vddio_ok  input  1  IO supply good; asynchronous
- vdd_ok  input  1  core supply good; asynchronous
- release_req  input  1  core request to release IOs; level
- force_poc  input  1  force poc high in any state
- fault_clr  input  1  one-cycle pulse; clears fault and timeout
- poc  output  1  power-on control to padring; 1 = IOs held safe
- io_ready  output  1  IOs released (state RUN)
- fault  output  1  sticky: supply dropped while in RUN
- timeout  output  1  sticky ARMED timeout (optional feature)
- state  output  2  debug: 00 HOLD, 01 WAIT, 10 ARMED, 11 RUN

Behaviour:
- Reset values (async, nreset=0): poc=1, io_ready=0, fault=0, timeout=0, state=HOLD, all counters 0, synchronizers 0.
- Synchronizers: 2-flop on vddio_ok and vdd_ok. sok = AND of both synced values.
- Debounce:
  - dcnt increments while sok=1 and saturates at DEBOUNCE; it clears to 0 the cycle sok=0.
  - deb_ok = (dcnt==DEBOUNCE).
- FSM, registered:
  - HOLD: on deb_ok -> WAIT; hcnt cleared.
  - WAIT: hcnt increments each cycle. sok=0 -> HOLD, hcnt cleared. hcnt==HOLD-1 -> ARMED.
  - ARMED: sok=0 -> HOLD. release_req=1 -> RUN.
  - RUN: sok=0 -> HOLD and set fault; this has priority over release_req. release_req=0 -> ARMED.
- Drop detection uses the synced, undebounced sok, so response to a drop is 2 sync cycles + 1.
- Outputs are registered from next-state, so poc/io_ready change on the same edge the state register changes:
  - poc = (next_state != RUN) | force_poc
  - io_ready = (next_state == RUN) & ~force_poc
- force_poc does not change the FSM. Deasserting it in RUN drops poc on the next edge.
- fault: set on RUN->HOLD caused by a drop. fault_clr clears it. Simultaneous set and clear -> set wins.
- Latency from vddio_ok/vdd_ok rising (both already high otherwise) to entering ARMED: 2 sync + DEBOUNCE + 1 + HOLD cycles.
- Counters never wrap: hcnt stops at HOLD-1; dcnt saturates.
- Mid-operation nreset: immediately returns to reset values, poc=1 asynchronously.

Optional Feature:
ASIC_IOPOC_WDOG_EN
- Defined:
  - wcnt counts cycles spent in ARMED and clears on leaving ARMED.
  - wcnt reaching WDOG-1 sets sticky timeout; FSM unaffected; wcnt saturates.
  - fault_clr clears timeout; set wins over simultaneous clear.
- Undefined: timeout tied 0; no wcnt logic.

Test Plan:
- Reset, both ok=1 from t0, release_req=1 (HOLD=16, DEBOUNCE=4) -> poc=1 until RUN entered at cycle 2+4+1+16+1=24 after nreset release; then poc=0, io_ready=1, state=11.
- vdd_ok glitches low for 2 cycles during WAIT at hcnt=10 -> state returns to HOLD, hcnt=0; re-debounce and full 16-cycle hold before ARMED; poc never drops.
- In RUN, vddio_ok falls -> poc=1, io_ready=0, fault=1 exactly 3 cycles later; fault stays 1 until a fault_clr pulse, and stays 1 if fault_clr coincides with a new drop.
- In RUN, release_req falls -> ARMED next edge, poc=1; release_req rises -> RUN, poc=0, fault unchanged at 0.
- force_poc=1 for 5 cycles in RUN -> poc=1, io_ready=0, state stays 11; after release, poc=0 on the next edge.
- With ASIC_IOPOC_WDOG_EN, WDOG=64, release_req=0 -> timeout=1 after 64 cycles in ARMED; fault_clr clears it. Without the macro, timeout stays 0.

Source files
------------

// File: rtl/asic_iopoc_ctrl.sv
// ---------------------------------------------------------------------------
// asic_iopoc_ctrl
//
// Generates the padring power-on-control (poc) line. The IO and core
// supply-good detectors are synchronized, debounced and followed by a hold
// time before the controller is ARMED. IOs are released (poc low) only while
// the core requests it. Any supply drop re-asserts poc.
//
// Optional feature (compile-time macro ASIC_IOPOC_WDOG_EN):
//   defined   -> ARMED-state watchdog; sticky timeout after WDOG cycles.
//   undefined -> timeout tied to 0, no watchdog logic.
//
// Ports:
//   clk          in   core clock (always-on domain)
//   nreset       in   asynchronous active-low reset
//   vddio_ok     in   IO supply good (asynchronous)
//   vdd_ok       in   core supply good (asynchronous)
//   release_req  in   core level request to release IOs
//   force_poc    in   force poc high; FSM keeps running
//   fault_clr    in   one-cycle pulse clearing fault / timeout
//   poc          out  1 = IOs held in safe state
//   io_ready     out  IOs released (RUN and not forced)
//   fault        out  sticky: supply dropped while in RUN
//   timeout      out  sticky ARMED watchdog expiry
//   state        out  debug: 00 HOLD, 01 WAIT, 10 ARMED, 11 RUN
//
// Handshake: release_req is a level. While it is high and supplies are good
// the block stays in RUN; dropping it returns to ARMED on the next edge.
// ---------------------------------------------------------------------------
module asic_iopoc_ctrl #(
    parameter int HOLD     = 16,
    parameter int DEBOUNCE = 4,
    parameter int CNTW     = 16,
    parameter int WDOG     = 4096
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       vddio_ok,
    input  logic       vdd_ok,
    input  logic       release_req,
    input  logic       force_poc,
    input  logic       fault_clr,
    output logic       poc,
    output logic       io_ready,
    output logic       fault,
    output logic       timeout,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ARMED = 2'b10,
        ST_RUN   = 2'b11
    } state_e;

    localparam longint CNT_MAX = (longint'(1) << CNTW) - 1;
    localparam logic [CNTW-1:0] DEB_MAX   = CNTW'(DEBOUNCE);
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD - 1);

    // Counters must never wrap, so every terminal value has to fit in CNTW.
    if (HOLD < 2 || DEBOUNCE < 1 || WDOG < 1 ||
        longint'(HOLD) > CNT_MAX || longint'(DEBOUNCE) > CNT_MAX ||
        longint'(WDOG) > CNT_MAX) begin : g_bad_params
        $error("asic_iopoc_ctrl: illegal HOLD/DEBOUNCE/WDOG/CNTW combination");
    end

    logic            vddio_s1_q, vddio_s1_d, vddio_s2_q, vddio_s2_d;
    logic            vdd_s1_q, vdd_s1_d, vdd_s2_q, vdd_s2_d;
    logic [CNTW-1:0] dcnt_q, dcnt_d;
    logic [CNTW-1:0] hcnt_q, hcnt_d;
    state_e          state_q, state_d;
    logic            poc_q, poc_d;
    logic            io_ready_q, io_ready_d;
    logic            fault_q, fault_d;
    logic            fault_set;
    logic            sok;
    logic            deb_ok;

    // Drop detection uses the synced but undebounced value for fast response.
    assign sok    = vddio_s2_q & vdd_s2_q;
    assign deb_ok = (dcnt_q == DEB_MAX);

    // Synchronizers and debounce counter.
    always_comb begin
        vddio_s1_d = vddio_ok;
        vddio_s2_d = vddio_s1_q;
        vdd_s1_d   = vdd_ok;
        vdd_s2_d   = vdd_s1_q;
        dcnt_d     = dcnt_q;
        if (!sok) begin
            dcnt_d = '0;
        end else if (!deb_ok) begin
            dcnt_d = dcnt_q + CNTW'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        fault_set = 1'b0;
        case (state_q)
            ST_HOLD: begin
                hcnt_d = '0;
                if (deb_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!sok) begin
                    state_d = ST_HOLD;
                    hcnt_d  = '0;
                end else if (hcnt_q == HOLD_LAST) begin
                    state_d = ST_ARMED;
                end else begin
                    hcnt_d = hcnt_q + CNTW'(1);
                end
            end
            ST_ARMED: begin
                if (!sok) begin
                    state_d = ST_HOLD;
                end else if (release_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A drop wins over a simultaneous release_req change.
                if (!sok) begin
                    state_d   = ST_HOLD;
                    fault_set = 1'b1;
                end else if (!release_req) begin
                    state_d = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // Outputs are registered from next-state so they move with the state flop.
    always_comb begin
        poc_d      = (state_d != ST_RUN) | force_poc;
        io_ready_d = (state_d == ST_RUN) & ~force_poc;
        fault_d    = fault_q;
        if (fault_set) begin
            fault_d = 1'b1;
        end else if (fault_clr) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vddio_s1_q <= 1'b0;
            vddio_s2_q <= 1'b0;
            vdd_s1_q   <= 1'b0;
            vdd_s2_q   <= 1'b0;
            dcnt_q     <= '0;
            hcnt_q     <= '0;
            state_q    <= ST_HOLD;
            poc_q      <= 1'b1;
            io_ready_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            vddio_s1_q <= vddio_s1_d;
            vddio_s2_q <= vddio_s2_d;
            vdd_s1_q   <= vdd_s1_d;
            vdd_s2_q   <= vdd_s2_d;
            dcnt_q     <= dcnt_d;
            hcnt_q     <= hcnt_d;
            state_q    <= state_d;
            poc_q      <= poc_d;
            io_ready_q <= io_ready_d;
            fault_q    <= fault_d;
        end
    end

`ifdef ASIC_IOPOC_WDOG_EN
    localparam logic [CNTW-1:0] WDOG_LAST = CNTW'(WDOG - 1);

    logic [CNTW-1:0] wcnt_q, wcnt_d;
    logic            timeout_q, timeout_d;
    logic            timeout_set;

    // wcnt counts only while staying in ARMED, so it reads 0 on entry.
    always_comb begin
        wcnt_d = '0;
        if (state_q == ST_ARMED && state_d == ST_ARMED) begin
            wcnt_d = (wcnt_q == WDOG_LAST) ? wcnt_q : wcnt_q + CNTW'(1);
        end
        timeout_set = (state_q == ST_ARMED) && (wcnt_q == WDOG_LAST);
        timeout_d   = timeout_q;
        if (timeout_set) begin
            timeout_d = 1'b1;
        end else if (fault_clr) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign poc      = poc_q;
    assign io_ready = io_ready_q;
    assign fault    = fault_q;
    assign state    = state_q;

endmodule

// File: tb/tb_asic_iopoc_ctrl.sv
`timescale 1ns/1ps
module tb_asic_iopoc_ctrl;

    localparam int HOLD     = 16;
    localparam int DEBOUNCE = 4;
    localparam int CNTW     = 16;
`ifdef ASIC_IOPOC_WDOG_EN
    localparam int WDOG     = 64;
`else
    localparam int WDOG     = 4096;
`endif

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_WAIT  = 2'b01;
    localparam logic [1:0] S_ARMED = 2'b10;
    localparam logic [1:0] S_RUN   = 2'b11;

    // Edges after reset release at which the bring-up reaches each state.
    localparam int E_WAIT  = 2 + DEBOUNCE + 1;          // 7
    localparam int E_ARMED = E_WAIT + HOLD;             // 23
    localparam int E_RUN   = E_ARMED + 1;               // 24

    logic       clk;
    logic       nreset;
    logic       vddio_ok;
    logic       vdd_ok;
    logic       release_req;
    logic       force_poc;
    logic       fault_clr;
    logic       poc;
    logic       io_ready;
    logic       fault;
    logic       timeout;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;
    logic [5:0] exp_q[$];

    typedef struct {
        string      name;
        logic       rel;
        logic       frc;
        logic       clr;
        logic       vio;
        logic       vd;
        int         cycles;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[11];

    asic_iopoc_ctrl #(
        .HOLD     (HOLD),
        .DEBOUNCE (DEBOUNCE),
        .CNTW     (CNTW),
        .WDOG     (WDOG)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .vddio_ok    (vddio_ok),
        .vdd_ok      (vdd_ok),
        .release_req (release_req),
        .force_poc   (force_poc),
        .fault_clr   (fault_clr),
        .poc         (poc),
        .io_ready    (io_ready),
        .fault       (fault),
        .timeout     (timeout),
        .state       (state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- driver tasks ----------------
    function automatic logic [5:0] pack(input logic p, input logic io, input logic f,
                                        input logic t, input logic [1:0] st);
        return {p, io, f, t, st};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [5:0] e);
        exp_q.push_back(e);
    endtask

    // Scoreboard: pop the oldest expectation and compare with the DUT now.
    task automatic check(input string name);
        logic [5:0] got;
        logic [5:0] e;
        got = {poc, io_ready, fault, timeout, state};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s got=%b exp=<empty queue>", name, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                failures++;
                $display("FAIL %s got={poc,io,flt,to,st}=%b exp=%b t=%0t", name, got, e, $time);
            end
        end
    endtask

    task automatic do_reset();
        nreset      = 1'b0;
        vddio_ok    = 1'b1;
        vdd_ok      = 1'b1;
        release_req = 1'b1;
        force_poc   = 1'b0;
        fault_clr   = 1'b0;
        step(2);
        push_exp(pack(1'b1, 1'b0, 1'b0, 1'b0, S_HOLD));
        check("reset_values");
        nreset = 1'b1;
    endtask

    task automatic bring_to_run();
        do_reset();
        step(E_RUN);
    endtask

    function automatic logic [1:0] glitch_state(input int e);
        if (e <= 19) return S_WAIT;
        if (e <= 25) return S_HOLD;
        if (e <= 41) return S_WAIT;
        if (e == 42) return S_ARMED;
        return S_RUN;
    endfunction

    // ---------------- test ----------------
    initial begin
        logic [1:0] st;

        //            name             rel   frc   clr   vio   vd   cyc  {poc,io,flt,to,st}
        vecs[0]  = '{"run_idle",       1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, pack(0, 1, 0, 0, S_RUN)};
        vecs[1]  = '{"rel_drop_1",     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, pack(1, 0, 0, 0, S_ARMED)};
        vecs[2]  = '{"rel_drop_4",     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, pack(1, 0, 0, 0, S_ARMED)};
        vecs[3]  = '{"force_1",        1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, pack(1, 0, 0, 0, S_RUN)};
        vecs[4]  = '{"force_5",        1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5, pack(1, 0, 0, 0, S_RUN)};
        vecs[5]  = '{"vio_drop_2",     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, pack(0, 1, 0, 0, S_RUN)};
        vecs[6]  = '{"vio_drop_3",     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, pack(1, 0, 1, 0, S_HOLD)};
        vecs[7]  = '{"vdd_drop_3",     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, pack(1, 0, 1, 0, S_HOLD)};
        vecs[8]  = '{"drop_after_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, pack(1, 0, 0, 0, S_HOLD)};
        vecs[9]  = '{"drop_clr_held",  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3, pack(1, 0, 1, 0, S_HOLD)};
        vecs[10] = '{"drop_force",     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3, pack(1, 0, 1, 0, S_HOLD)};

        nreset      = 1'b0;
        vddio_ok    = 1'b0;
        vdd_ok      = 1'b0;
        release_req = 1'b0;
        force_poc   = 1'b0;
        fault_clr   = 1'b0;

        // Bring-up timing, checked every cycle.
        do_reset();
        for (int e = 1; e <= E_RUN + 2; e++) begin
            step(1);
            st = (e < E_WAIT) ? S_HOLD : (e < E_ARMED) ? S_WAIT :
                 (e == E_ARMED) ? S_ARMED : S_RUN;
            push_exp(pack(st != S_RUN, st == S_RUN, 1'b0, 1'b0, st));
            check($sformatf("bringup_e%0d", e));
        end

        // Table of single-stimulus reactions from steady RUN.
        for (int i = 0; i < 11; i++) begin
            bring_to_run();
            release_req = vecs[i].rel;
            force_poc   = vecs[i].frc;
            fault_clr   = vecs[i].clr;
            vddio_ok    = vecs[i].vio;
            vdd_ok      = vecs[i].vd;
            push_exp(vecs[i].exp);
            step(vecs[i].cycles);
            check(vecs[i].name);
        end

        // vdd_ok glitch during WAIT at hcnt=10: restart debounce and full hold.
        do_reset();
        step(E_WAIT + 10);
        vdd_ok = 1'b0;
        for (int e = E_WAIT + 11; e <= 44; e++) begin
            step(1);
            if (e == 19) vdd_ok = 1'b1;
            st = glitch_state(e);
            push_exp(pack(st != S_RUN, st == S_RUN, 1'b0, 1'b0, st));
            check($sformatf("glitch_e%0d", e));
        end

        // Fault is sticky across recovery and clears only on fault_clr.
        bring_to_run();
        vddio_ok = 1'b0;
        push_exp(pack(1, 0, 1, 0, S_HOLD));
        step(3);
        check("fault_set");
        vddio_ok = 1'b1;
        push_exp(pack(0, 1, 1, 0, S_RUN));
        step(E_RUN);
        check("fault_sticky_run");
        fault_clr = 1'b1;
        push_exp(pack(0, 1, 0, 0, S_RUN));
        step(1);
        fault_clr = 1'b0;
        check("fault_cleared");
        push_exp(pack(0, 1, 0, 0, S_RUN));
        step(3);
        check("fault_stays_clear");

        // force_poc release drops poc on the next edge.
        bring_to_run();
        force_poc = 1'b1;
        push_exp(pack(1, 0, 0, 0, S_RUN));
        step(5);
        check("force_held");
        force_poc = 1'b0;
        push_exp(pack(0, 1, 0, 0, S_RUN));
        step(1);
        check("force_released");

        // release_req fall / rise.
        bring_to_run();
        release_req = 1'b0;
        push_exp(pack(1, 0, 0, 0, S_ARMED));
        step(1);
        check("rel_fall_armed");
        release_req = 1'b1;
        push_exp(pack(0, 1, 0, 0, S_RUN));
        step(1);
        check("rel_rise_run");

        // ARMED watchdog.
        bring_to_run();
        release_req = 1'b0;
        step(1);
`ifdef ASIC_IOPOC_WDOG_EN
        push_exp(pack(1, 0, 0, 0, S_ARMED));
        step(WDOG - 1);
        check("wdog_before");
        push_exp(pack(1, 0, 0, 1, S_ARMED));
        step(1);
        check("wdog_expired");
        push_exp(pack(1, 0, 0, 1, S_ARMED));
        step(5);
        check("wdog_sticky");
        release_req = 1'b1;
        push_exp(pack(0, 1, 0, 1, S_RUN));
        step(1);
        check("wdog_sticky_run");
        fault_clr = 1'b1;
        push_exp(pack(0, 1, 0, 0, S_RUN));
        step(1);
        fault_clr = 1'b0;
        check("wdog_cleared");
`else
        push_exp(pack(1, 0, 0, 0, S_ARMED));
        step(200);
        check("no_wdog_timeout");
`endif

        // Mid-operation asynchronous reset forces poc high without a clock edge.
        bring_to_run();
        #2;
        nreset = 1'b0;
        #1;
        push_exp(pack(1, 0, 0, 0, S_HOLD));
        check("async_reset");
        step(1);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
